// File: rtl/segment_swapchain.sv
// Double-buffered read-segment sequencer: takes a host switch request, waits for
// its trigger, flips the active segment and counts finite repetitions to STOP.
module segment_swapchain #(
    parameter int NumSegment = 2,
    parameter int IdxWidth   = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  UPDATE,
    input  logic                  REQ_SEGMENT,
    input  logic [15:0]           REP,
    input  logic [7:0]            TRANSITION_MODE,
    input  logic [63:0]           TRANSITION_VALUE,
    input  logic [63:0]           SYS_TIME,
    input  logic [3:0]            GPIO_IN,
    input  logic [NumSegment-1:0] STEP,
    input  logic [IdxWidth-1:0]   IDX_0,
    input  logic [IdxWidth-1:0]   IDX_1,
    output logic                  SEGMENT,
    output logic                  STOP,
    output logic                  BUSY
);

    localparam logic [7:0]  ModeSyncIdx  = 8'h00;
    localparam logic [7:0]  ModeSysTime  = 8'h01;
    localparam logic [7:0]  ModeGpio     = 8'h02;
    localparam logic [15:0] RepInfinite  = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SYNC_IDX,
        WAIT_SYS_TIME,
        WAIT_GPIO,
        RUN_FINITE
    } state_t;

    state_t        state_q, state_d;
    logic          segment_q, segment_d;
    logic          stop_q, stop_d;
    logic          busy_q, busy_d;
    logic [16:0]   loop_cnt_q, loop_cnt_d;
    logic          req_q, req_d;
    logic [15:0]   rep_q, rep_d;
    logic [7:0]    mode_q, mode_d;
    logic [63:0]   value_q, value_d;
    logic [3:0]    gpio_prev_q;

    logic          req_idx_zero;
    logic          act_idx_zero;
    logic          trigger;
    logic          loop_event;

    assign req_idx_zero = ((req_q ? IDX_1 : IDX_0) == '0);
    assign act_idx_zero = ((segment_q ? IDX_1 : IDX_0) == '0);
    assign loop_event   = STEP[segment_q] && act_idx_zero;

    always_comb begin
        trigger = 1'b0;
        case (mode_q)
            ModeSyncIdx: trigger = STEP[req_q] && req_idx_zero;
            ModeSysTime: trigger = (SYS_TIME >= value_q);
            ModeGpio:    trigger = GPIO_IN[value_q[1:0]] && !gpio_prev_q[value_q[1:0]];
            default:     trigger = 1'b0;
        endcase
    end

    // A new request always takes priority over any trigger or loop event.
    always_comb begin
        state_d    = state_q;
        segment_d  = segment_q;
        stop_d     = stop_q;
        busy_d     = busy_q;
        loop_cnt_d = loop_cnt_q;
        req_d      = req_q;
        rep_d      = rep_q;
        mode_d     = mode_q;
        value_d    = value_q;

        if (UPDATE) begin
            req_d   = REQ_SEGMENT;
            rep_d   = REP;
            mode_d  = TRANSITION_MODE;
            value_d = TRANSITION_VALUE;
            if (REP == RepInfinite) begin
                segment_d = REQ_SEGMENT;
                stop_d    = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end else begin
                case (TRANSITION_MODE)
                    ModeSyncIdx: state_d = WAIT_SYNC_IDX;
                    ModeSysTime: state_d = WAIT_SYS_TIME;
                    ModeGpio:    state_d = WAIT_GPIO;
                    default:     state_d = IDLE;
                endcase
                if (TRANSITION_MODE <= ModeGpio) begin
                    stop_d = 1'b0;
                    busy_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
        end else begin
            case (state_q)
                WAIT_SYNC_IDX, WAIT_SYS_TIME, WAIT_GPIO: begin
                    if (trigger) begin
                        segment_d  = req_q;
                        busy_d     = 1'b0;
                        loop_cnt_d = '0;
                        state_d    = RUN_FINITE;
                    end
                end
                RUN_FINITE: begin
                    if (loop_event) begin
                        if (loop_cnt_q == {1'b0, rep_q}) begin
                            stop_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            loop_cnt_d = loop_cnt_q + 17'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            segment_q   <= 1'b0;
            stop_q      <= 1'b0;
            busy_q      <= 1'b0;
            loop_cnt_q  <= '0;
            req_q       <= 1'b0;
            rep_q       <= '0;
            mode_q      <= '0;
            value_q     <= '0;
            gpio_prev_q <= '0;
        end else begin
            state_q     <= state_d;
            segment_q   <= segment_d;
            stop_q      <= stop_d;
            busy_q      <= busy_d;
            loop_cnt_q  <= loop_cnt_d;
            req_q       <= req_d;
            rep_q       <= rep_d;
            mode_q      <= mode_d;
            value_q     <= value_d;
            gpio_prev_q <= GPIO_IN;
        end
    end

    assign SEGMENT = segment_q;
    assign STOP    = stop_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_segment_swapchain.sv
// Bench for segment_swapchain: directed vector table, hand-written corner
// sequences, then randomized traffic against a pass-counting reference model.
module tb_segment_swapchain;

    logic        CLK;
    logic        RST_N;
    logic        UPDATE;
    logic        REQ_SEGMENT;
    logic [15:0] REP;
    logic [7:0]  TRANSITION_MODE;
    logic [63:0] TRANSITION_VALUE;
    logic [63:0] SYS_TIME;
    logic [3:0]  GPIO_IN;
    logic [1:0]  STEP;
    logic [15:0] IDX_0;
    logic [15:0] IDX_1;
    logic        SEGMENT;
    logic        STOP;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    segment_swapchain #(.NumSegment(2), .IdxWidth(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .UPDATE(UPDATE), .REQ_SEGMENT(REQ_SEGMENT),
        .REP(REP), .TRANSITION_MODE(TRANSITION_MODE), .TRANSITION_VALUE(TRANSITION_VALUE),
        .SYS_TIME(SYS_TIME), .GPIO_IN(GPIO_IN), .STEP(STEP), .IDX_0(IDX_0), .IDX_1(IDX_1),
        .SEGMENT(SEGMENT), .STOP(STOP), .BUSY(BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        bit          upd;
        bit          req;
        logic [15:0] rep;
        logic [7:0]  mode;
        logic [1:0]  step;
        logic [15:0] idx0;
        logic [15:0] idx1;
        bit          e_seg;
        bit          e_stop;
        bit          e_busy;
    } vec_t;

    vec_t vecs[13];

    // Reference model: tracks the pending trigger kind and the number of full
    // passes still owed, rather than an up-counter.
    bit          m_seg, m_stop, m_busy, m_run, m_req;
    int          m_wait;
    int          m_left;
    logic [15:0] m_rep;
    logic [63:0] m_val;
    logic [3:0]  m_prev;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_output(input string name, input bit e_seg, input bit e_stop, input bit e_busy);
        checks++;
        if (SEGMENT !== e_seg || STOP !== e_stop || BUSY !== e_busy) begin
            errors++;
            $display("[TB] FAIL %s: got seg=%0b stop=%0b busy=%0b, expected seg=%0b stop=%0b busy=%0b",
                     name, SEGMENT, STOP, BUSY, e_seg, e_stop, e_busy);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        UPDATE = v.upd;
        REQ_SEGMENT = v.req;
        REP = v.rep;
        TRANSITION_MODE = v.mode;
        STEP = v.step;
        IDX_0 = v.idx0;
        IDX_1 = v.idx1;
        tick();
        UPDATE = 1'b0;
        STEP = 2'b00;
    endtask

    task automatic request(input bit req, input logic [15:0] rep, input logic [7:0] mode,
                           input logic [63:0] val);
        UPDATE = 1'b1;
        REQ_SEGMENT = req;
        REP = rep;
        TRANSITION_MODE = mode;
        TRANSITION_VALUE = val;
        tick();
        UPDATE = 1'b0;
    endtask

    task automatic model_reset();
        m_seg = 0; m_stop = 0; m_busy = 0; m_run = 0; m_req = 0;
        m_wait = -1; m_left = 0; m_rep = '0; m_val = '0; m_prev = '0;
    endtask

    task automatic model_step();
        bit fire;
        bit [1:0] pin;
        if (UPDATE) begin
            m_req = REQ_SEGMENT;
            m_rep = REP;
            m_val = TRANSITION_VALUE;
            m_run = 0;
            if (REP == 16'hFFFF) begin
                m_seg = REQ_SEGMENT; m_stop = 0; m_busy = 0; m_wait = -1;
            end else if (TRANSITION_MODE <= 8'd2) begin
                m_stop = 0; m_busy = 1; m_wait = int'(TRANSITION_MODE);
            end else begin
                m_busy = 0; m_wait = -1;
            end
        end else if (m_wait >= 0) begin
            pin = m_val[1:0];
            case (m_wait)
                0: fire = STEP[m_req] && ((m_req ? IDX_1 : IDX_0) == 0);
                1: fire = (SYS_TIME >= m_val);
                default: fire = GPIO_IN[pin] && !m_prev[pin];
            endcase
            if (fire) begin
                m_seg = m_req; m_busy = 0; m_wait = -1; m_run = 1;
                m_left = int'(m_rep) + 1;
            end
        end else if (m_run) begin
            if (STEP[m_seg] && ((m_seg ? IDX_1 : IDX_0) == 0)) begin
                m_left--;
                if (m_left == 0) begin
                    m_stop = 1; m_run = 0;
                end
            end
        end
        m_prev = GPIO_IN;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        UPDATE = 0; REQ_SEGMENT = 0; REP = '0; TRANSITION_MODE = '0; TRANSITION_VALUE = '0;
        SYS_TIME = '0; GPIO_IN = '0; STEP = '0; IDX_0 = '0; IDX_1 = '0;
        model_reset();
        #3;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1, 1, 16'hFFFF, 8'h00, 2'b00, 16'd0, 16'd0, 1, 0, 0};
        vecs[1]  = '{1, 0, 16'hFFFF, 8'h00, 2'b00, 16'd0, 16'd0, 0, 0, 0};
        vecs[2]  = '{1, 1, 16'd2,    8'h00, 2'b00, 16'd0, 16'd0, 0, 0, 1};
        vecs[3]  = '{0, 0, 16'd0,    8'h00, 2'b10, 16'd0, 16'd3, 0, 0, 1};
        vecs[4]  = '{0, 0, 16'd0,    8'h00, 2'b10, 16'd0, 16'd0, 1, 0, 0};
        vecs[5]  = '{0, 0, 16'd0,    8'h00, 2'b10, 16'd0, 16'd0, 1, 0, 0};
        vecs[6]  = '{0, 0, 16'd0,    8'h00, 2'b01, 16'd0, 16'd0, 1, 0, 0};
        vecs[7]  = '{0, 0, 16'd0,    8'h00, 2'b10, 16'd0, 16'd0, 1, 0, 0};
        vecs[8]  = '{0, 0, 16'd0,    8'h00, 2'b10, 16'd0, 16'd5, 1, 0, 0};
        vecs[9]  = '{0, 0, 16'd0,    8'h00, 2'b10, 16'd0, 16'd0, 1, 1, 0};
        vecs[10] = '{0, 0, 16'd0,    8'h00, 2'b00, 16'd0, 16'd0, 1, 1, 0};
        vecs[11] = '{0, 0, 16'd0,    8'h00, 2'b10, 16'd0, 16'd0, 1, 1, 0};
        vecs[12] = '{0, 0, 16'd0,    8'h00, 2'b11, 16'd0, 16'd0, 1, 1, 0};

        RST_N = 1'b0;
        UPDATE = 0; REQ_SEGMENT = 0; REP = '0; TRANSITION_MODE = '0; TRANSITION_VALUE = '0;
        SYS_TIME = '0; GPIO_IN = '0; STEP = '0; IDX_0 = '0; IDX_1 = '0;
        #3;
        check_output("reset", 0, 0, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d", i), vecs[i].e_seg, vecs[i].e_stop, vecs[i].e_busy);
        end

        // System-time trigger: future target, then a target already passed.
        SYS_TIME = 64'd990;
        request(0, 16'd0, 8'h01, 64'd1000);
        check_output("st_wait", 1, 0, 1);
        for (int t = 991; t <= 1000; t++) begin
            SYS_TIME = 64'(t);
            tick();
            if (t < 1000) check_output("st_ramp", 1, 0, 1);
            else          check_output("st_fire", 0, 0, 0);
        end
        SYS_TIME = 64'd990;
        request(1, 16'd0, 8'h01, 64'd5);
        check_output("st_past_wait", 0, 0, 1);
        tick();
        check_output("st_past_fire", 1, 0, 0);

        // GPIO trigger: pre-high level, foreign pin pulse, then a real edge.
        GPIO_IN = 4'b0100;
        tick();
        request(0, 16'd0, 8'h02, 64'd2);
        check_output("gpio_wait", 1, 0, 1);
        tick(); check_output("gpio_level", 1, 0, 1);
        tick(); check_output("gpio_level2", 1, 0, 1);
        GPIO_IN = 4'b0110; tick(); check_output("gpio_pin1_hi", 1, 0, 1);
        GPIO_IN = 4'b0100; tick(); check_output("gpio_pin1_lo", 1, 0, 1);
        GPIO_IN = 4'b0000; tick(); check_output("gpio_low", 1, 0, 1);
        GPIO_IN = 4'b0100; tick(); check_output("gpio_edge", 0, 0, 0);

        // Infinite request overrides a pending GPIO wait.
        request(1, 16'hFFFF, 8'h00, 64'd0);
        check_output("ovr_inf1", 1, 0, 0);
        GPIO_IN = 4'b0000;
        request(0, 16'd3, 8'h02, 64'd0);
        check_output("ovr_pending", 1, 0, 1);
        tick(); check_output("ovr_pending2", 1, 0, 1);
        request(0, 16'hFFFF, 8'h02, 64'd0);
        check_output("ovr_inf0", 0, 0, 0);
        GPIO_IN = 4'b0001; tick(); check_output("ovr_stale_edge", 0, 0, 0);
        GPIO_IN = 4'b0000;

        // UPDATE coincident with the completing loop event wins.
        request(1, 16'd0, 8'h00, 64'd0);
        check_output("col_wait", 0, 0, 1);
        STEP = 2'b10; IDX_1 = 16'd0;
        tick(); check_output("col_switch", 1, 0, 0);
        request(0, 16'd0, 8'h01, 64'd0);
        check_output("col_update", 1, 0, 1);
        STEP = 2'b00;
        tick(); check_output("col_next", 0, 0, 0);

        // Unknown mode leaves segment and STOP untouched.
        STEP = 2'b01; IDX_0 = 16'd0;
        tick(); check_output("unk_stop", 0, 1, 0);
        STEP = 2'b00;
        request(1, 16'd5, 8'h07, 64'd0);
        check_output("unk_mode", 0, 1, 0);
        STEP = 2'b10; IDX_1 = 16'd0;
        tick(); check_output("unk_after", 0, 1, 0);
        STEP = 2'b00;

        // Asynchronous reset mid-run.
        request(1, 16'd3, 8'h01, 64'd0);
        check_output("rst_wait", 0, 0, 1);
        tick(); check_output("rst_run", 1, 0, 0);
        STEP = 2'b10; IDX_1 = 16'd0;
        tick(); check_output("rst_cnt1", 1, 0, 0);
        STEP = 2'b00;
        #2 RST_N = 1'b0;
        #1 check_output("rst_async", 0, 0, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            UPDATE = ($urandom_range(0, 19) == 0);
            REQ_SEGMENT = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            REP = (r == 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            TRANSITION_MODE = (r < 3) ? 8'h00 : (r < 6) ? 8'h01 : (r < 9) ? 8'h02 : 8'h07;
            SYS_TIME = SYS_TIME + 64'($urandom_range(0, 2));
            if (TRANSITION_MODE == 8'h01)
                TRANSITION_VALUE = SYS_TIME + 64'($urandom_range(0, 60)) - 64'd10;
            else
                TRANSITION_VALUE = 64'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) GPIO_IN = 4'($urandom);
            STEP = 2'($urandom_range(0, 3));
            IDX_0 = 16'($urandom_range(0, 2));
            IDX_1 = 16'($urandom_range(0, 2));
            model_step();
            tick();
            check_output($sformatf("rand%0d", c), m_seg, m_stop, m_busy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/segment_swapchain.md
Name: segment_swapchain

Overview:
- Sequences the double-buffered (two-segment) read side of the modulation and STM memories.
- Accepts a host segment-switch request with repeat count and transition mode, waits for the selected trigger, then flips the active read segment.
- Counts finite repetitions of the new segment and raises STOP when they are done.
- One instance per datapath (mod, stm), sitting between the controller register file and the segment timers/readers.

Parameters:
- NumSegment, 2, number of segments; this design supports exactly 2.
- IdxWidth, 16, width of the per-segment read index.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- UPDATE  in  1  one-cycle strobe; latch the request fields below
- REQ_SEGMENT  in  1  requested read segment
- REP  in  16  repeat count; 16'hFFFF means infinite
- TRANSITION_MODE  in  8  0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO
- TRANSITION_VALUE  in  64  SYS_TIME target, or GPIO pin select in bits [1:0]
- SYS_TIME  in  64  free-running system time
- GPIO_IN  in  4  synchronous external trigger inputs
- STEP  in  NumSegment  per-segment index-advance strobe from the timers
- IDX_0, IDX_1  in  IdxWidth  current index per segment, valid when the matching STEP bit is high
- SEGMENT  out  1  active read segment
- STOP  out  1  finite repetition completed; reader holds output
- BUSY  out  1  a transition is pending

Behaviour:
- Reset values: SEGMENT=0, STOP=0, BUSY=0, state=IDLE, loop counter=0, latched fields=0, GPIO edge register=0.
- States: IDLE, WAIT_SYNC_IDX, WAIT_SYS_TIME, WAIT_GPIO, RUN_FINITE.
- UPDATE is accepted in every state.
  - It overrides the current state: cancels any pending wait and aborts any finite run.
  - It latches REQ_SEGMENT, REP, TRANSITION_MODE and TRANSITION_VALUE.
  - UPDATE wins over a trigger or loop event in the same cycle.
- Infinite request (REP=16'hFFFF), any mode:
  - Next cycle: SEGMENT=REQ_SEGMENT, STOP=0, BUSY=0, state=IDLE.
  - Latency is 1 cycle.
- Finite request: STOP=0 and BUSY=1 on the next cycle; the state is chosen by mode.
  - Unknown mode: the request is dropped; BUSY=0; state IDLE; SEGMENT and STOP are unchanged.
- WAIT_SYNC_IDX trigger: STEP[req] is high and IDX of the requested segment is 0.
- WAIT_SYS_TIME trigger: SYS_TIME >= TRANSITION_VALUE (unsigned, 64 bits).
  - A target already in the past fires on the first cycle in this state.
- WAIT_GPIO trigger: a rising edge on GPIO_IN[TRANSITION_VALUE[1:0]].
  - Edge register is a 1-cycle delayed copy of GPIO_IN, updated every cycle.
  - A level that is already high does not fire.
- On any trigger, on the next cycle:
  - SEGMENT=req, BUSY=0, loop counter=0, state=RUN_FINITE.
- RUN_FINITE:
  - Loop event = STEP[SEGMENT] high and IDX of the active segment equal to 0.
  - On each loop event, the counter increments.
  - When a loop event occurs with counter == REP: STOP=1 next cycle, state=IDLE, counter stays.
  - Net effect: REP+1 full passes, then STOP when the reader re-enters index 0.
  - REP=0 means one pass.
  - The loop counter is 17 bits, so REP=16'hFFFE cannot overflow.
- STOP stays high until the next accepted UPDATE that reaches a switch or a new finite request.
- A request for the segment that is already active behaves identically; it restarts counting and clears STOP.
- Reset asserted mid-wait or mid-run: all state returns to reset values immediately; the pending request is lost.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Infinite switch: reset; UPDATE with REQ=1, REP=FFFF, mode 0x00 -> SEGMENT=1 one cycle later; BUSY never set; STOP=0.
- Sync-idx finite: UPDATE with REQ=1, REP=2, mode 0x00; pulse STEP[1] with IDX_1 sequence 3,0 -> BUSY=1 until the STEP with IDX_1=0, SEGMENT=1 the cycle after.
  - Then three further STEP[1] events at IDX_1=0 -> STOP=1 after the third, not before.
- Sys-time: TRANSITION_VALUE=1000, SYS_TIME ramps from 990 -> SEGMENT flips the cycle after SYS_TIME=1000.
  - Second run with value=5 while SYS_TIME=990 -> flips on the cycle after entering WAIT_SYS_TIME.
- GPIO: TRANSITION_VALUE=2, GPIO_IN[2] held high before UPDATE -> no switch.
  - GPIO_IN[2] low then high -> switch one cycle after the rising edge.
  - A GPIO_IN[1] pulse is ignored.
- Override and collision: finite request pending in WAIT_GPIO, then UPDATE with REP=FFFF, REQ=0 -> SEGMENT=0, BUSY=0.
  - UPDATE coincident with the completing loop event -> STOP stays 0 and the new request is processed.
  - Unknown mode 0x07 -> no change.
- Reset mid-run: RST_N low during RUN_FINITE with counter=1 -> SEGMENT=0, STOP=0, BUSY=0 immediately, asynchronously to CLK.
